// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl
// Sequencing controller for the 3x3 convolution line-buffer datapath.
// Accepts a raster-scan pixel stream (valid/ready), drives the shared shift
// enable of the line buffers, tracks row/column and flags every cycle on
// which a complete 3x3 window sits in the buffers.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   start          begin a frame (only looked at in IDLE)
//   abort          synchronous frame abort, beats start and accept
//   in_vld/in_rdy  pixel handshake from the source
//   out_rdy        convolution engine can take a window
//   sr_we          line-buffer shift enable (same cycle as the accept)
//   win_vld        registered: full window present, centre win_row/win_col
//   frame_done     one-cycle pulse at end of frame
//   busy           controller not idle
module conv_window_ctrl #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int CW    = $clog2(IMG_W),
    parameter int RW    = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic          out_rdy,
    output logic          sr_we,
    output logic          win_vld,
    output logic [RW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic          accept;
    logic          last_col;
    logic          last_px;
    logic          win_hit;

    assign last_col = (col == CW'(IMG_W - 1));
    assign last_px  = last_col && (row == RW'(IMG_H - 1));
    // Pixel (r,c) with r>=2, c>=2 completes the window centred at (r-1,c-1).
    assign win_hit  = (row >= RW'(2)) && (col >= CW'(2));

    always_comb begin
        state_nxt  = state;
        // abort masks the handshake so no pixel is shifted in on that edge.
        in_rdy     = (state == RUN) && out_rdy && !abort;
        accept     = in_vld && in_rdy;
        sr_we      = accept;
        frame_done = (state == DONE) && !abort;
        busy       = (state != IDLE);
        case (state)
            IDLE: if (start && !abort) state_nxt = RUN;
            RUN: begin
                if (abort)                  state_nxt = IDLE;
                else if (accept && last_px) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Position counters: only move in RUN on an accept, zero everywhere else.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (abort || state != RUN) begin
            row <= '0;
            col <= '0;
        end else if (accept) begin
            if (last_px) begin
                row <= '0;
                col <= '0;
            end else if (last_col) begin
                row <= row + RW'(1);
                col <= '0;
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Window flag is a single-cycle pulse per qualifying accept; a stall
    // leaves it low rather than re-issuing the previous window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_vld <= 1'b0;
            win_row <= '0;
            win_col <= '0;
        end else if (abort) begin
            win_vld <= 1'b0;
        end else begin
            win_vld <= accept && win_hit;
            if (accept && win_hit) begin
                win_row <= row - RW'(1);
                win_col <= col - CW'(1);
            end
        end
    end

endmodule
